// File: rtl/vm_display_pkg.sv
// rtl/vm_display_pkg.sv - shared constants for the vending machine seven-segment display path
package vm_display_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_W     = 8;
  localparam int SEG_W       = 7;
  localparam int DIGIT_IDX_W = 2;
  localparam int BUS_W       = NUM_DIGITS * DIGIT_W;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

  // Active-high segment patterns (g..a) used by the producer of board7SD
  localparam logic [SEG_W-1:0] HEX_0 = 7'h3F;
  localparam logic [SEG_W-1:0] HEX_1 = 7'h06;
  localparam logic [SEG_W-1:0] HEX_2 = 7'h5B;
  localparam logic [SEG_W-1:0] HEX_3 = 7'h4F;
  localparam logic [SEG_W-1:0] HEX_4 = 7'h66;
  localparam logic [SEG_W-1:0] HEX_5 = 7'h6D;
  localparam logic [SEG_W-1:0] HEX_6 = 7'h7D;
  localparam logic [SEG_W-1:0] HEX_7 = 7'h07;
  localparam logic [SEG_W-1:0] HEX_8 = 7'h7F;
  localparam logic [SEG_W-1:0] HEX_9 = 7'h6F;
  localparam logic [SEG_W-1:0] HEX_A = 7'h77;
  localparam logic [SEG_W-1:0] HEX_B = 7'h7C;
  localparam logic [SEG_W-1:0] HEX_C = 7'h39;
  localparam logic [SEG_W-1:0] HEX_D = 7'h5E;
  localparam logic [SEG_W-1:0] HEX_E = 7'h79;
  localparam logic [SEG_W-1:0] HEX_F = 7'h71;

  // Nibble to active-high segment pattern
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return HEX_0;
      4'h1: return HEX_1;
      4'h2: return HEX_2;
      4'h3: return HEX_3;
      4'h4: return HEX_4;
      4'h5: return HEX_5;
      4'h6: return HEX_6;
      4'h7: return HEX_7;
      4'h8: return HEX_8;
      4'h9: return HEX_9;
      4'hA: return HEX_A;
      4'hB: return HEX_B;
      4'hC: return HEX_C;
      4'hD: return HEX_D;
      4'hE: return HEX_E;
      default: return HEX_F;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - digit bus in, multiplexed display drive out (brightness port with SEG_DIMMING_EN)
interface seven_seg_scanner_if;
  import vm_display_pkg::*;

  logic                  en;
  logic [BUS_W-1:0]      board7SD;
  logic [NUM_DIGITS-1:0] an;
  logic [SEG_W-1:0]      seg;
  logic                  dp;
  logic                  frame_tick;
`ifdef SEG_DIMMING_EN
  logic [3:0]            brightness;
`endif

  // master: the side producing board7SD; slave: the scanner
  modport master (
    output en,
    output board7SD,
`ifdef SEG_DIMMING_EN
    output brightness,
`endif
    input  an,
    input  seg,
    input  dp,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  board7SD,
`ifdef SEG_DIMMING_EN
    input  brightness,
`endif
    output an,
    output seg,
    output dp,
    output frame_tick
  );

endinterface

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - slot counter, digit index and blank/drive phase for the display scanner
module scan_timer
  import vm_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  output logic [DIGIT_IDX_W-1:0] digit_o,
  output logic                   in_blank_o,
  output logic                   frame_start_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DIGIT_IDX_W-1:0] digit_q, digit_d;

  // Advance cnt every cycle; terminal count wraps it and steps the digit. Disabled parks at (0,0).
  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (!en_i) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + DIGIT_IDX_W'(1);
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o       = digit_q;
  assign in_blank_o    = (cnt_q < BLANK_END);
  assign frame_start_o = en_i && (digit_q == '0) && (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - frame-snapshotting 4-digit common-anode scanner (optional PWM dimming via SEG_DIMMING_EN)
module seven_seg_scanner
  import vm_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic               clk,
  input  logic               rst,
  seven_seg_scanner_if.slave dsp
);

  logic [DIGIT_IDX_W-1:0] digit;
  logic                   in_blank;
  logic                   frame_start;

  scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .en_i          (dsp.en),
    .digit_o       (digit),
    .in_blank_o    (in_blank),
    .frame_start_o (frame_start)
  );

  logic [BUS_W-1:0]      snap_q, snap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [DIGIT_W-1:0]    cur_byte;
  logic                  lit;

`ifdef SEG_DIMMING_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] bright_q, bright_d;

  // Free-running 0..14 PWM phase; brightness is latched with the frame snapshot
  always_comb begin
    pwm_d    = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
    bright_d = frame_start ? dsp.brightness : bright_q;
    lit      = (pwm_q < bright_q);
  end

  // PWM and brightness registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q    <= '0;
      bright_q <= '0;
    end else begin
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
    end
  end
`else
  assign lit = 1'b1;
`endif

  assign cur_byte = snap_q[{digit, 3'b000} +: DIGIT_W];

  // Next display drive: blank unless enabled, past the blanking gap and lit
  always_comb begin
    snap_d       = frame_start ? dsp.board7SD : snap_q;
    frame_tick_d = frame_start;
    an_d         = AN_OFF;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    if (dsp.en && !in_blank && lit) begin
      an_d  = ~(NUM_DIGITS'(1) << digit);
      seg_d = ~cur_byte[SEG_W-1:0];
      dp_d  = ~cur_byte[DIGIT_W-1];
    end
  end

  // Snapshot and registered outputs; reset blanks the display at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q       <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign dsp.an         = an_q;
  assign dsp.seg        = seg_q;
  assign dsp.dp         = dp_q;
  assign dsp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed bench for seven_seg_scanner (dimming steps with SEG_DIMMING_EN)
module tb_seven_seg_scanner;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam logic [31:0] PAT_A = 32'h3F06_5B4F;
  localparam logic [31:0] PAT_F = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seven_seg_scanner_if dsp_if ();

  seven_seg_scanner #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dsp (dsp_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock, sample 1 ns later, and check the one-hot anode property
  task automatic tick();
    @(posedge clk);
    #1;
    chk("an_onehot", 32'($countones(~dsp_if.an) <= 1), 32'd1);
  endtask

  // Expected outputs after edge m of a scan started at (digit 0, cnt 0)
  task automatic check_slot(input int m, input logic [31:0] snap, input int bright);
    int          d;
    int          c;
    logic [7:0]  b;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    d     = (m / RD) % 4;
    c     = m % RD;
    b     = snap[8*d +: 8];
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (c >= BC && (m % 15) < bright) begin
      e_an  = ~(4'b0001 << d);
      e_seg = ~b[6:0];
      e_dp  = ~b[7];
    end
    chk($sformatf("an m=%0d", m),  32'(dsp_if.an),  32'(e_an));
    chk($sformatf("seg m=%0d", m), 32'(dsp_if.seg), 32'(e_seg));
    chk($sformatf("dp m=%0d", m),  32'(dsp_if.dp),  32'(e_dp));
    chk($sformatf("frame_tick m=%0d", m), 32'(dsp_if.frame_tick), 32'((m % (4*RD)) == 0));
  endtask

  task automatic check_blank(input string tag);
    chk({tag, " an"},  32'(dsp_if.an),  32'hF);
    chk({tag, " seg"}, 32'(dsp_if.seg), 32'h7F);
    chk({tag, " dp"},  32'(dsp_if.dp),  32'h1);
    chk({tag, " frame_tick"}, 32'(dsp_if.frame_tick), 32'h0);
  endtask

`ifdef SEG_DIMMING_EN
  task automatic run_dim(input int bright);
    rst = 1'b1;
    dsp_if.brightness = 4'(bright);
    dsp_if.board7SD   = PAT_A;
    tick();
    tick();
    rst = 1'b0;
    for (int m = 0; m < 64; m++) begin
      tick();
      check_slot(m, PAT_A, bright);
    end
  endtask
`endif

  initial begin
    dsp_if.en       = 1'b1;
    dsp_if.board7SD = PAT_A;
`ifdef SEG_DIMMING_EN
    dsp_if.brightness = 4'd15;
`endif

    // Reset held for 5 cycles
    repeat (5) tick();
    check_blank("reset");
    rst = 1'b0;

    // Frame 0 with a mid-frame bus change that must not show until frame 1
    for (int m = 0; m < 32; m++) begin
      tick();
      check_slot(m, PAT_A, 15);
      if (m == 12) dsp_if.board7SD = PAT_F;
    end
    for (int m = 32; m < 84; m++) begin
      tick();
      check_slot(m, PAT_F, 15);
    end

    // Drop en in digit 2 drive phase
    dsp_if.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_blank($sformatf("en_low %0d", i));
    end

    // Re-enable: scan restarts at digit 0 with a fresh snapshot
    dsp_if.en = 1'b1;
    for (int m = 0; m < 36; m++) begin
      tick();
      check_slot(m, PAT_F, 15);
    end

    // Asynchronous reset between edges during digit 0 drive phase
    #2;
    rst = 1'b1;
    #1;
    check_blank("async_rst");
    dsp_if.board7SD = 32'h0;
    tick();
    check_blank("rst_held");
    rst = 1'b0;
    for (int m = 0; m < 32; m++) begin
      tick();
      check_slot(m, 32'h0, 15);
    end

`ifdef SEG_DIMMING_EN
    run_dim(5);
    run_dim(0);
    run_dim(15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
